sms_sega_mapper: RTL
====================

// Module: sms_sega_mapper
// PURPOSE
//   Cartridge-side responder for the SMS cartridge slot: decodes the slot strobes driven by the
//   board, holds the Sega paging registers (FFFC-FFFF), and drives read data back as
//   cart_data/cart_data_en from external synchronous ROM and optional battery SRAM.
//   It sits on the far side of the board's cart_* bus and does all translation from Z80 address to ROM/SRAM address.
// PARAMETERS
//   ROM_AW   19  ROM byte-address width (2^ROM_AW bytes); bank numbers wrap modulo 2^(ROM_AW-14)
//   SRAM_EN  1   1 = 16 KB cart SRAM present; 0 = ctrl[3] ignored, SRAM ports held at 0
// PORTS
//   MCLK          in   1       master clock; all logic on posedge
//   ext_reset     in   1       synchronous active-high reset
//   cart_address  in   16      Z80 address from board
//   cart_cs       in   1       active-high slot select (board ~CE3)
//   cart_oe       in   1       active-high read strobe
//   cart_wr       in   1       active-high write strobe
//   cart_mreq     in   1       active-high memory cycle (board ~MREQ); IO cycles never decoded
//   cart_data_wr  in   8       write data from board
//   cart_data     out  8       read data to board
//   cart_data_en  out  1       cart_data valid; board muxes it onto DATA
//   rom_address   out  ROM_AW  synchronous ROM address
//   rom_q         in   8       ROM data, valid one MCLK after rom_address
//   sram_address  out  14      SRAM address {bank, A[12:0]}
//   sram_data     out  8       SRAM write data
//   sram_wren     out  1       one-MCLK SRAM write pulse
//   sram_q        in   8       SRAM data, valid one MCLK after sram_address
// BEHAVIOUR
//   Reset: bank0=0, bank1=1, bank2=2, ctrl=0; all outputs 0; read pipeline and write capture cleared.
//   Reset mid-cycle aborts the cycle: cart_data_en low on the reset edge, no pending write commits.
//   Registers: FFFC ctrl (bit3 RAM enable in slot 2, bit2 RAM bank), FFFD bank0, FFFE bank1, FFFF bank2.
//   Write capture: every cycle with cart_wr&cart_mreq sampled high, latch address and cart_data_wr.
//   Commit on first cycle cart_wr samples low after high (falling strobe), using the latched values.
//   Register writes snoop FFFC-FFFF regardless of cart_cs. The commit is exactly one update per Z80 write.
//   Read map (cart_cs&cart_oe&cart_mreq, address A):
//     0000-03FF -> ROM {0, A[13:0]}                      (first 1 KB fixed to page 0)
//     0400-3FFF -> ROM {bank0, A[13:0]}
//     4000-7FFF -> ROM {bank1, A[13:0]}
//     8000-BFFF -> ctrl[3]&SRAM_EN ? SRAM {ctrl[2], A[12:0]} : ROM {bank2, A[13:0]}
//     C000-FFFF -> no response, cart_data_en stays 0 (system RAM region)
//   Bank arithmetic: 8-bit bank truncated to ROM_AW-14 LSBs; no overflow into other fields.
//   Read pipeline: edge E0 samples qualified read, registers rom_/sram_address; edge E1 captures
//     rom_q/sram_q into cart_data and sets cart_data_en. Latency 2 MCLK from qualification.
//   While read stays qualified, address re-registered each cycle; cart_data tracks within 2 MCLK.
//   cart_data_en clears on the first edge the qualification samples low (not pipelined); cart_data holds.
//   SRAM write: committed write to 8000-BFFF with cart_cs and ctrl[3]&SRAM_EN -> sram_wren=1 for
//     exactly one MCLK with sram_address {ctrl[2], A[12:0]}; ROM-region writes discarded.
//   Simultaneous commit and read on one edge: commit applies first; read uses updated banks.
//   Write to FFFC-FFFF updates the register only; board RAM handles the mirror copy.
// TESTING
//   Reset, read 0x4000 -> rom_address=0x04000, cart_data_en high 2 MCLK later with rom_q value.
//   Write FFFF=0x05, read 0x8123 -> rom_address=0x14123; write FFFD=0x03: read 0x0100 -> 0x00100, 0x0400 -> 0x0C400.
//   ROM_AW=17: write FFFE=0x0A, read 0x4001 -> rom_address=0x08001 (bank wraps to 2).
//   FFFC=0x08, write 0x8010=0x55 -> one sram_wren pulse, addr 0x0010, data 0x55; FFFC=0x0C, read 0x8010 -> sram_address 0x2010.
//   IO write (cart_mreq=0) addr 0xFFFF data 0x07 -> bank2 unchanged; read 0xC000 -> cart_data_en never asserts.
//   Assert ext_reset while reading 0x8000 with bank2=5 -> cart_data_en low next edge; reread -> rom_address=0x08000.

Source files
------------

// File: rtl/sms_sega_mapper_if.sv
// sms_sega_mapper_if
//   Cartridge-slot bus between the console board (master) and the cartridge
//   responder (slave).
//   cart_address  16  Z80 address from board
//   cart_cs        1  active-high slot select
//   cart_oe        1  active-high read strobe
//   cart_wr        1  active-high write strobe
//   cart_mreq      1  active-high memory cycle (IO cycles have it low)
//   cart_data_wr   8  write data from board
//   cart_data      8  read data back to board
//   cart_data_en   1  cart_data valid
interface sms_sega_mapper_if;
  logic [15:0] cart_address;
  logic        cart_cs;
  logic        cart_oe;
  logic        cart_wr;
  logic        cart_mreq;
  logic [7:0]  cart_data_wr;
  logic [7:0]  cart_data;
  logic        cart_data_en;

  modport master (
    output cart_address, cart_cs, cart_oe, cart_wr, cart_mreq, cart_data_wr,
    input  cart_data, cart_data_en
  );

  modport slave (
    input  cart_address, cart_cs, cart_oe, cart_wr, cart_mreq, cart_data_wr,
    output cart_data, cart_data_en
  );
endinterface

// File: rtl/sms_sega_mapper.sv
// sms_sega_mapper
//   Cartridge-side Sega mapper: snoops the paging registers at FFFC-FFFF,
//   translates Z80 reads into synchronous ROM / battery SRAM accesses and
//   returns the byte on cart_data with cart_data_en, and turns committed
//   writes into slot 2 into single-cycle SRAM write pulses.
// Parameters
//   ROM_AW   ROM byte-address width; bank numbers wrap modulo 2^(ROM_AW-14)
//   SRAM_EN  1 = 16 KB cart SRAM present; 0 = ctrl[3] ignored, SRAM outputs 0
// Ports
//   MCLK          master clock, all logic on posedge
//   ext_reset     synchronous active-high reset
//   cart          slot bus (slave side)
//   rom_address   synchronous ROM address; rom_q valid one MCLK later
//   sram_address  SRAM address {bank, A[12:0]}; sram_q valid one MCLK later
//   sram_data     SRAM write data
//   sram_wren     one-MCLK SRAM write pulse
module sms_sega_mapper #(
  parameter int ROM_AW  = 19,
  parameter int SRAM_EN = 1
) (
  input  logic              MCLK,
  input  logic              ext_reset,
  sms_sega_mapper_if.slave  cart,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [13:0]       sram_address,
  output logic [7:0]        sram_data,
  output logic              sram_wren,
  input  logic [7:0]        sram_q
);

  localparam int   BW     = ROM_AW - 14;
  localparam logic SRAM_ON = (SRAM_EN != 0);

  // Paging registers
  logic [7:0] ctrl, bank0, bank1, bank2;
  logic [7:0] ctrl_nx, bank0_nx, bank1_nx, bank2_nx;

  // Write capture: last sampled address/data/select while the strobe was high
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_cs;
  logic        wr_held;
  logic        commit;
  logic        sram_wr;

  // Read pipeline
  logic              rd_qual;
  logic              rd_hit;
  logic              rd_is_sram;
  logic              rd_stage;
  logic              rd_sram;
  logic [7:0]        rom_bank;
  logic [BW-1:0]     bank_t;
  logic [ROM_AW-1:0] rom_addr_nx;
  logic [13:0]       sram_addr_rd;

  always_comb begin
    // Commit happens on the first edge the strobe samples low after a capture,
    // so each Z80 write produces exactly one register/SRAM update.
    commit   = wr_held & ~cart.cart_wr;

    ctrl_nx  = ctrl;
    bank0_nx = bank0;
    bank1_nx = bank1;
    bank2_nx = bank2;
    if (commit && (wr_addr[15:2] == 14'h3FFF)) begin
      unique case (wr_addr[1:0])
        2'd0:    ctrl_nx  = wr_data;
        2'd1:    bank0_nx = wr_data;
        2'd2:    bank1_nx = wr_data;
        default: bank2_nx = wr_data;
      endcase
    end

    // SRAM write decision uses the ctrl value in force when the write landed.
    sram_wr = commit & wr_cs & (wr_addr[15:14] == 2'b10) & ctrl[3] & SRAM_ON;
  end

  always_comb begin
    rd_qual    = cart.cart_cs & cart.cart_oe & cart.cart_mreq;
    rd_hit     = rd_qual & (cart.cart_address[15:14] != 2'b11);
    // Decode against the post-commit register values so a read on the same
    // edge as a commit sees the new mapping.
    rd_is_sram = (cart.cart_address[15:14] == 2'b10) & ctrl_nx[3] & SRAM_ON;

    unique case (cart.cart_address[15:14])
      2'b00:   rom_bank = (cart.cart_address[13:10] == 4'd0) ? 8'd0 : bank0_nx;
      2'b01:   rom_bank = bank1_nx;
      default: rom_bank = bank2_nx;
    endcase

    bank_t       = BW'(rom_bank);
    rom_addr_nx  = {bank_t, cart.cart_address[13:0]};
    sram_addr_rd = {ctrl_nx[2], cart.cart_address[12:0]};
  end

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      ctrl              <= '0;
      bank0             <= 8'd0;
      bank1             <= 8'd1;
      bank2             <= 8'd2;
      wr_addr           <= '0;
      wr_data           <= '0;
      wr_cs             <= 1'b0;
      wr_held           <= 1'b0;
      rd_stage          <= 1'b0;
      rd_sram           <= 1'b0;
      rom_address       <= '0;
      sram_address      <= '0;
      sram_data         <= '0;
      sram_wren         <= 1'b0;
      cart.cart_data    <= '0;
      cart.cart_data_en <= 1'b0;
    end else begin
      ctrl  <= ctrl_nx;
      bank0 <= bank0_nx;
      bank1 <= bank1_nx;
      bank2 <= bank2_nx;

      if (cart.cart_wr && cart.cart_mreq) begin
        wr_addr <= cart.cart_address;
        wr_data <= cart.cart_data_wr;
        wr_cs   <= cart.cart_cs;
        wr_held <= 1'b1;
      end else if (commit) begin
        wr_held <= 1'b0;
      end

      sram_wren <= sram_wr;
      if (sram_wr) begin
        sram_address <= {ctrl[2], wr_addr[12:0]};
        sram_data    <= wr_data;
      end else if (rd_hit && rd_is_sram) begin
        sram_address <= sram_addr_rd;
      end

      if (rd_hit && !rd_is_sram)
        rom_address <= rom_addr_nx;

      // An SRAM read that collides with an SRAM write pulse loses the address
      // this cycle; dropping the stage makes it simply retry next edge.
      rd_stage <= rd_hit & ~(sram_wr & rd_is_sram);
      rd_sram  <= rd_is_sram;

      // Enable drops immediately when qualification goes away; data holds.
      if (rd_stage && rd_hit) begin
        cart.cart_data    <= rd_sram ? sram_q : rom_q;
        cart.cart_data_en <= 1'b1;
      end else begin
        cart.cart_data_en <= 1'b0;
      end
    end
  end

endmodule
